// File: rtl/c7bcsr_timer_ctrl.sv
// Timer control/status block: TCFG register, timer sequencing FSM, pending latch.
// Optional expiry counter enabled by defining C7BCSR_TIMER_EXPCNT_EN.
module c7bcsr_timer_ctrl #(
  parameter int TW = 30
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          tcfg_we,
  input  logic [TW+1:0] tcfg_wdata,
  input  logic          ticlr_we,
  input  logic          ticlr_wdata,
  output logic [TW+1:0] tcfg_q,
  output logic [TW-1:0] tval_q,
  output logic          ti_pending,
  output logic [7:0]    expcnt,
  output logic          tmr_init,
  output logic          tmr_en,
  output logic          tmr_periodic,
  output logic [TW-1:0] tmr_initval,
  input  logic [TW+1:0] tmr_timeval,
  input  logic          tmr_intr
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   run_expire;
  logic   unused_timeval_lsbs;

  // The two low count bits are a sub-tick prescale and are not software visible.
  assign unused_timeval_lsbs = ^tmr_timeval[1:0];
  assign tval_q              = tmr_timeval[TW+1:2];
  assign tmr_periodic        = tcfg_q[1];
  assign tmr_initval         = tcfg_q[TW+1:2];
  assign run_expire          = (state == S_RUN) && tmr_intr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_en    = 1'b0;
    tmr_init  = 1'b0;
    case (state)
      S_OFF:  state_nxt = S_OFF;
      S_ARM: begin
        tmr_en    = 1'b1;
        tmr_init  = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        tmr_en = 1'b1;
        if (tmr_intr && !tcfg_q[1]) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_OFF;
    endcase
    // A configuration write overrides whatever the sequencer was doing.
    if (tcfg_we) begin
      state_nxt = tcfg_wdata[0] ? S_ARM : S_OFF;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg_q <= '0;
    end else if (tcfg_we) begin
      tcfg_q <= tcfg_wdata;
    end
  end

  // An expiry in the same cycle as a software clear keeps the interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ti_pending <= 1'b0;
    end else if (run_expire) begin
      ti_pending <= 1'b1;
    end else if (ticlr_we && ticlr_wdata) begin
      ti_pending <= 1'b0;
    end
  end

`ifdef C7BCSR_TIMER_EXPCNT_EN
  logic [7:0] expcnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      expcnt_q <= 8'd0;
    end else if (tcfg_we) begin
      expcnt_q <= 8'd0;
    end else if (run_expire && (expcnt_q != 8'hff)) begin
      expcnt_q <= expcnt_q + 8'd1;
    end
  end

  assign expcnt = expcnt_q;
`else
  assign expcnt = 8'd0;
`endif

endmodule
